// File: rtl/dmadd_pkg.sv
// Shared definitions for the delta-MADD sequencer.
// Holds the field widths, opcode constants, default parameter values,
// the sequencer state enumeration and the operand FIFO entry layout.
package dmadd_pkg;

    localparam int unsigned OP_W  = 2;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned DAT_W = 4;
    localparam int unsigned RES_W = 12;
    localparam int unsigned CNT_W = 5;

    localparam int unsigned DEF_RUN_CYCLES = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    localparam logic [OP_W-1:0] OP_MIN  = 2'b00;
    localparam logic [OP_W-1:0] OP_MAX  = 2'b01;
    localparam logic [OP_W-1:0] OP_MADD = 2'b10;
    localparam logic [OP_W-1:0] OP_RSV  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_INIT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // One operand FIFO entry: 9 bits total.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [DAT_W-1:0] data;
        logic             last;
    } opd_entry_t;

    function automatic logic is_reserved(input logic [OP_W-1:0] op);
        return op == OP_RSV;
    endfunction

endpackage

// File: rtl/dmadd_seq_if.sv
// Bus bundle between the sequencer and its environment.
// Carries the command, operand and result handshakes plus the engine
// control outputs (dm_*) and the engine result input (dm_out).
// master: command/operand source, engine and result sink.
// slave : the sequencer.
interface dmadd_seq_if;
    import dmadd_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;

    logic             opd_valid;
    logic             opd_ready;
    logic [IDX_W-1:0] opd_index;
    logic [DAT_W-1:0] opd_data;
    logic             opd_last;

    logic             dm_rst_n;
    logic [IDX_W-1:0] dm_index;
    logic [DAT_W-1:0] dm_data;
    logic [OP_W-1:0]  dm_insn;
    logic             dm_load;
    logic             dm_run;
    logic [RES_W-1:0] dm_out;

    logic             res_valid;
    logic             res_ready;
    logic [RES_W-1:0] res_data;

    logic             err;

    modport master (
        output cmd_valid, cmd_op,
        output opd_valid, opd_index, opd_data, opd_last,
        output dm_out, res_ready,
        input  cmd_ready, opd_ready,
        input  dm_rst_n, dm_index, dm_data, dm_insn, dm_load, dm_run,
        input  res_valid, res_data, err
    );

    modport slave (
        input  cmd_valid, cmd_op,
        input  opd_valid, opd_index, opd_data, opd_last,
        input  dm_out, res_ready,
        output cmd_ready, opd_ready,
        output dm_rst_n, dm_index, dm_data, dm_insn, dm_load, dm_run,
        output res_valid, res_data, err
    );

endinterface

// File: rtl/dmadd_seq_fifo.sv
// Operand FIFO for the delta-MADD sequencer.
// Ports: clk, rst_n (sync, active low), i_push/i_wdata (write side),
// o_ready (not full, from the registered level only), i_pop (read side),
// o_empty, o_head (show-ahead head entry).
module dmadd_seq_fifo
    import dmadd_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  opd_entry_t i_wdata,
    output logic       o_ready,
    input  logic       i_pop,
    output logic       o_empty,
    output opd_entry_t o_head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    opd_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    // Pointer increment with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A full FIFO refuses a push even when the same cycle pops.
    assign o_ready = (r_level != LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && o_ready;
    assign w_pop   = i_pop && !o_empty;

    // Pointers and fill level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: ;
            endcase
        end
    end

    // Storage array; contents are don't-care while the level says empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/dmadd_seq.sv
// Delta-MADD command sequencer.
// Accepts a command, clears and initialises the engine, streams operands
// from the FIFO as dm_load cycles, runs the engine for RUN_CYCLES cycles and
// presents the captured engine result on the result handshake.
// Ports: clk, rst_n (sync, active low), bus (dmadd_seq_if.slave).
module dmadd_seq
    import dmadd_pkg::*;
#(
    parameter int unsigned RUN_CYCLES = DEF_RUN_CYCLES,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    dmadd_seq_if.slave bus
);

    state_t           r_state;
    state_t           w_next;
    logic [OP_W-1:0]  r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic [RES_W-1:0] r_res_data;

    logic             w_accept;
    logic             w_rsv_hit;
    logic             w_pop;
    logic             w_capture;
    logic             w_fifo_empty;
    opd_entry_t       w_head;
    opd_entry_t       w_wdata;

    assign w_wdata = '{idx: bus.opd_index, data: bus.opd_data, last: bus.opd_last};

    dmadd_seq_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.opd_valid),
        .i_wdata (w_wdata),
        .o_ready (bus.opd_ready),
        .i_pop   (w_pop),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    // State, opcode, run counter, error pulse and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_res_data <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= w_rsv_hit;
            if (w_accept)  r_op       <= bus.cmd_op;
            if (w_capture) r_res_data <= bus.dm_out;
            r_cnt <= (r_state == ST_RUN) ? r_cnt + CNT_W'(1) : '0;
        end
    end

    // Next state and output decode.
    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        w_rsv_hit     = 1'b0;
        w_pop         = 1'b0;
        w_capture     = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.dm_rst_n  = rst_n && (r_state != ST_CLEAR);
        bus.dm_index  = '0;
        bus.dm_data   = '0;
        bus.dm_insn   = '0;
        bus.dm_load   = 1'b0;
        bus.dm_run    = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = r_res_data;
        bus.err       = r_err;

        case (r_state)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    if (is_reserved(bus.cmd_op)) begin
                        w_rsv_hit = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        w_next   = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                w_next = ST_INIT;
            end
            ST_INIT: begin
                bus.dm_insn = r_op;
                w_next      = ST_LOAD;
            end
            ST_LOAD: begin
                bus.dm_insn = r_op;
                // Empty FIFO simply stalls here with dm_load low.
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    bus.dm_load  = 1'b1;
                    bus.dm_index = w_head.idx;
                    bus.dm_data  = w_head.data;
                    if (w_head.last) w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.dm_insn = r_op;
                bus.dm_run  = 1'b1;
                if (r_cnt == CNT_W'(RUN_CYCLES - 1)) begin
                    w_capture = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                // dm_run stays high so the engine holds its result.
                bus.dm_insn   = r_op;
                bus.dm_run    = 1'b1;
                bus.res_valid = 1'b1;
                if (bus.res_ready) w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmadd_seq.sv
// Self-checking bench for dmadd_seq with a behavioural delta-MADD engine.
module tb_dmadd_seq;
    import dmadd_pkg::*;

    localparam int unsigned RUNS = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmadd_seq_if bus ();

    dmadd_seq #(.RUN_CYCLES(RUNS), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural engine: MIN/MAX over operand index, MADD sums index*data.
    logic [11:0] eng_acc;
    logic        eng_first;
    always @(posedge clk) begin
        if (!bus.dm_rst_n) begin
            eng_acc   <= 12'd0;
            eng_first <= 1'b1;
        end else if (bus.dm_load) begin
            eng_first <= 1'b0;
            case (bus.dm_insn)
                OP_MIN:  if (eng_first || 12'(bus.dm_index) < eng_acc) eng_acc <= 12'(bus.dm_index);
                OP_MAX:  if (eng_first || 12'(bus.dm_index) > eng_acc) eng_acc <= 12'(bus.dm_index);
                OP_MADD: eng_acc <= eng_acc + 12'(bus.dm_index) * 12'(bus.dm_data);
                default: ;
            endcase
        end
    end
    assign bus.dm_out = eng_acc;

    typedef struct { logic [3:0] idx; logic [3:0] dat; } ld_t;
    typedef struct { logic [11:0] res; int nload; } sb_t;
    typedef struct {
        logic [1:0]  op;
        int          n;
        logic [3:0]  i0, d0, i1, d1;
        logic [11:0] exp;
    } vec_t;

    ld_t  load_q[$];
    sb_t  sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [1:0] cur_op = 2'b00;
    int   run_cnt = 0;
    int   loads_this = 0;
    logic prev_rv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: load stream, run length and result scoreboard.
    always @(negedge clk) begin : mon
        ld_t e;
        sb_t s;
        if (!rst_n) begin
            run_cnt    = 0;
            loads_this = 0;
            prev_rv    = 1'b0;
        end else begin
            if (bus.dm_load) begin
                loads_this++;
                check("dm_insn_on_load", 32'(bus.dm_insn), 32'(cur_op));
                if (load_q.size() == 0) begin
                    check("unexpected_load", 32'(bus.dm_load), 32'(0));
                end else begin
                    e = load_q.pop_front();
                    check("dm_index", 32'(bus.dm_index), 32'(e.idx));
                    check("dm_data", 32'(bus.dm_data), 32'(e.dat));
                end
            end
            if (bus.dm_run && !bus.res_valid) run_cnt++;
            if (bus.res_valid && !prev_rv) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 32'(bus.res_valid), 32'(0));
                end else begin
                    s = sb_q.pop_front();
                    check("res_data", 32'(bus.res_data), 32'(s.res));
                    check("run_cycles", 32'(run_cnt), 32'(RUNS));
                    check("load_count", 32'(loads_this), 32'(s.nload));
                end
                run_cnt    = 0;
                loads_this = 0;
            end
            prev_rv = bus.res_valid;
        end
    end

    // All driving tasks start and end at posedge+1.
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push_opd(input logic [3:0] idx, input logic [3:0] dat, input logic last);
        logic acc;
        ld_t  e;
        acc = 1'b0;
        bus.opd_valid = 1'b1; bus.opd_index = idx; bus.opd_data = dat; bus.opd_last = last;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            acc = bus.opd_ready;
            if (acc) begin e.idx = idx; e.dat = dat; load_q.push_back(e); end
            step();
            if (acc) break;
        end
        bus.opd_valid = 1'b0;
        if (!acc) check("opd_push_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic prefilled);
        logic acc;
        acc = 1'b0;
        if (op != OP_RSV) cur_op = op;
        bus.cmd_valid = 1'b1; bus.cmd_op = op;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            step();
            if (acc) break;
        end
        bus.cmd_valid = 1'b0;
        if (!acc) check("cmd_accept_timeout", 32'(0), 32'(1));
        if (op != OP_RSV) begin
            @(negedge clk);
            check("clear_dm_rst_n", 32'(bus.dm_rst_n), 32'(0));
            @(negedge clk);
            check("init_dm_insn", 32'(bus.dm_insn), 32'(op));
            check("init_no_load_run", 32'({bus.dm_load, bus.dm_run, bus.dm_rst_n}), 32'(3'b001));
            if (prefilled) begin
                @(negedge clk);
                check("first_load_latency", 32'(bus.dm_load), 32'(1));
            end
            step();
        end
    endtask

    task automatic wait_result();
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.res_valid) begin acc = 1'b1; break; end
        end
        if (!acc) check("result_timeout", 32'(0), 32'(1));
        step();
        @(negedge clk);
        check("back_to_idle", 32'({bus.cmd_ready, bus.res_valid, bus.dm_run}), 32'(3'b100));
        step();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got time limit, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        vec_t vecs[6];
        sb_t  s;
        int   errs;
        logic seen_rv;
        logic acc;

        vecs[0] = '{OP_MIN,  2, 4'd3,  4'd1,  4'd7,  4'd1,  12'd3};
        vecs[1] = '{OP_MAX,  1, 4'd5,  4'd1,  4'd0,  4'd0,  12'd5};
        vecs[2] = '{OP_MADD, 2, 4'd4,  4'd2,  4'd9,  4'd3,  12'd35};
        vecs[3] = '{OP_MIN,  2, 4'd9,  4'd2,  4'd2,  4'd5,  12'd2};
        vecs[4] = '{OP_MAX,  2, 4'd1,  4'd1,  4'd15, 4'd15, 12'd15};
        vecs[5] = '{OP_MADD, 2, 4'd15, 4'd15, 4'd15, 4'd15, 12'd450};

        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00;
        bus.opd_valid = 1'b0; bus.opd_index = 4'd0; bus.opd_data = 4'd0; bus.opd_last = 1'b0;
        bus.res_ready = 1'b1;

        // Reset state.
        repeat (3) step();
        @(negedge clk);
        check("rst_dm_ctrl", 32'({bus.dm_rst_n, bus.dm_load, bus.dm_run}), 32'(0));
        check("rst_dm_bus", 32'({bus.dm_insn, bus.dm_index, bus.dm_data}), 32'(0));
        check("rst_res", 32'({bus.res_valid, bus.res_data, bus.err}), 32'(0));
        check("rst_fifo_ready", 32'(bus.opd_ready), 32'(1));
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'({bus.cmd_ready, bus.dm_rst_n}), 32'(2'b11));
        step();

        // Table: even vectors push operands first, odd ones issue the command first.
        for (int i = 0; i < 6; i++) begin
            s.res = vecs[i].exp; s.nload = vecs[i].n; sb_q.push_back(s);
            if (i % 2 == 0) begin
                if (vecs[i].n == 1) push_opd(vecs[i].i0, vecs[i].d0, 1'b1);
                else begin
                    push_opd(vecs[i].i0, vecs[i].d0, 1'b0);
                    push_opd(vecs[i].i1, vecs[i].d1, 1'b1);
                end
                do_cmd(vecs[i].op, 1'b1);
            end else begin
                do_cmd(vecs[i].op, 1'b0);
                @(negedge clk);
                check("stall_no_load", 32'(bus.dm_load), 32'(0));
                step();
                if (vecs[i].n == 1) push_opd(vecs[i].i0, vecs[i].d0, 1'b1);
                else begin
                    push_opd(vecs[i].i0, vecs[i].d0, 1'b0);
                    push_opd(vecs[i].i1, vecs[i].d1, 1'b1);
                end
            end
            wait_result();
        end

        // FIFO fills with no command pending; fifth push blocked until LOAD pops.
        s.res = 12'd30; s.nload = 4; sb_q.push_back(s);
        s.res = 12'd6;  s.nload = 1; sb_q.push_back(s);
        push_opd(4'd1, 4'd1, 1'b0);
        push_opd(4'd2, 4'd2, 1'b0);
        push_opd(4'd3, 4'd3, 1'b0);
        push_opd(4'd4, 4'd4, 1'b1);
        @(negedge clk);
        check("fifo_full_ready", 32'(bus.opd_ready), 32'(0));
        step();
        bus.opd_valid = 1'b1; bus.opd_index = 4'd6; bus.opd_data = 4'd1; bus.opd_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_push_blocked", 32'(bus.opd_ready), 32'(0));
            step();
        end
        do_cmd(OP_MADD, 1'b1);
        acc = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc = bus.opd_ready;
            if (acc) begin load_q.push_back('{idx: 4'd6, dat: 4'd1}); end
            step();
            if (acc) break;
        end
        bus.opd_valid = 1'b0;
        check("blocked_push_released", 32'(acc), 32'(1));
        wait_result();
        do_cmd(OP_MAX, 1'b1);
        wait_result();

        // Reserved opcode: single err pulse, no engine activity.
        do_cmd(OP_RSV, 1'b0);
        errs = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            errs += int'(bus.err);
            check("rsv_cmd_ready", 32'(bus.cmd_ready), 32'(1));
            check("rsv_no_dm", 32'({bus.dm_load, bus.dm_run, bus.dm_rst_n, bus.dm_insn}), 32'(5'b00100));
            step();
        end
        check("rsv_err_pulses", 32'(errs), 32'(1));

        // Reset during RUN aborts the command and empties the FIFO.
        bus.res_ready = 1'b0;
        push_opd(4'd2, 4'd3, 1'b1);
        push_opd(4'd8, 4'd8, 1'b0);
        do_cmd(OP_MIN, 1'b1);
        acc = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc = bus.dm_run;
            step();
            if (acc) break;
        end
        check("reached_run", 32'(acc), 32'(1));
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        load_q.delete();
        seen_rv = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            seen_rv |= bus.res_valid;
            step();
        end
        check("abort_no_result", 32'(seen_rv), 32'(0));
        @(negedge clk);
        check("abort_idle", 32'({bus.cmd_ready, bus.dm_run, bus.opd_ready}), 32'(3'b101));
        check("abort_res_data", 32'(bus.res_data), 32'(0));
        step();
        bus.res_ready = 1'b1;
        s.res = 12'd11; s.nload = 1; sb_q.push_back(s);
        push_opd(4'd11, 4'd1, 1'b1);
        do_cmd(OP_MAX, 1'b1);
        wait_result();

        repeat (3) step();
        check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
        check("loads_drained", 32'(load_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmadd_seq.md
DMADD_SEQ -- requirements
Module: dmadd_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with the ports listed below.
REQ-002 Parameter RUN_CYCLES, default 16: number of cycles dm_run is held before result capture.
REQ-003 Parameter FIFO_DEPTH, default 4: number of entries in the operand FIFO.
REQ-004 Port clk, input, 1 bit: the single clock.
REQ-005 Port rst_n, input, 1 bit: synchronous reset, active low.
REQ-006 Port cmd_valid, input, 1 bit: command request.
REQ-007 Port cmd_ready, output, 1 bit: command accepted when high together with cmd_valid.
REQ-008 Port cmd_op, input, 2 bits: 00 MIN, 01 MAX, 10 MADD, 11 reserved.
REQ-009 Port opd_valid and opd_ready, 1 bit each: operand handshake (input and output respectively).
REQ-010 Port opd_index, input, 4 bits: operand slot.
REQ-011 Port opd_data, input, 4 bits: operand value.
REQ-012 Port opd_last, input, 1 bit: marks the final operand of a command.
REQ-013 Outputs dm_rst_n (1 bit), dm_index (4), dm_data (4), dm_insn (2), dm_load (1) and dm_run (1): these drive the delta-MADD engine.
REQ-014 Port dm_out, input, 12 bits: the engine result.
REQ-015 Outputs res_valid (1) and res_data (12), with input res_ready (1): result handshake.
REQ-016 Output err, 1 bit: pulses for one cycle when a reserved opcode is rejected.

Function
REQ-017 The state machine SHALL have states IDLE, CLEAR, INIT, LOAD, RUN and DONE.
REQ-018 cmd_ready SHALL be high only in IDLE.
REQ-019 A reserved opcode (11) SHALL be accepted, stay in IDLE and pulse err for one cycle on the next cycle.
REQ-020 Accepting a valid opcode SHALL latch it into op_q and move to CLEAR.
REQ-021 CLEAR SHALL last one cycle with dm_rst_n=0, then move to INIT.
REQ-022 INIT SHALL last one cycle with dm_insn=op_q and dm_load=dm_run=0, then move to LOAD.
REQ-023 In LOAD, each cycle with a non-empty FIFO SHALL pop one entry and drive dm_load=1 with dm_index and dm_data from that entry.
REQ-024 In LOAD, an empty-FIFO cycle SHALL drive dm_load=0 and stall the sequence.
REQ-025 Popping an entry with last=1 SHALL move to RUN on the next cycle.
REQ-026 RUN SHALL drive dm_run=1 for exactly RUN_CYCLES cycles, counted by a 5-bit counter, then move to DONE.
REQ-027 On entry to DONE, res_data SHALL be registered from dm_out.
REQ-028 DONE SHALL keep dm_run=1 so the engine stays halted and never re-initialises.
REQ-029 res_valid SHALL be high only in DONE.
REQ-030 The cycle with res_valid and res_ready both high SHALL return the FSM to IDLE.
REQ-031 dm_insn SHALL equal op_q in every state from INIT through DONE, and 00 in IDLE.
REQ-032 The FIFO SHALL accept a push whenever it is not full, in any state.
REQ-033 opd_ready SHALL be derived from the registered count only: full means no push, even in a cycle that pops.
REQ-034 A simultaneous push and pop on a non-full FIFO SHALL leave the count unchanged.
REQ-035 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-036 Operands pushed before a command is accepted SHALL be retained and consumed in LOAD.
REQ-037 Command latency: acceptance in cycle T SHALL give CLEAR at T+1, INIT at T+2 and the first possible load at T+3.

Reset
REQ-038 While rst_n=0 the block SHALL drive state=IDLE, an empty FIFO, dm_rst_n=0, dm_load=0, dm_run=0, dm_insn=00, dm_index=0, dm_data=0, res_valid=0, res_data=0 and err=0.
REQ-039 A reset asserted mid-command SHALL abort the command and discard FIFO contents, with no result produced.
REQ-040 dm_rst_n SHALL equal rst_n AND NOT(state==CLEAR).

Structure
REQ-041 Package dmadd_pkg SHALL hold the opcode constants, the state enumeration and the default parameter values.
REQ-042 The FIFO SHALL be the sub-module dmadd_seq_fifo, 9 bits wide (index, data, last).
REQ-043 The sequencer FSM SHALL remain in dmadd_seq.

Verification
REQ-044 MIN, operands (3,1) then (7,1,last) -> exactly two dm_load cycles, then 16 dm_run cycles, then res_data=3.
REQ-045 MAX, operands (5,1,last) -> res_data=5.
REQ-046 MADD, operands (4,2) then (9,3,last) -> dm_load pattern 4/2 then 9/3, and res_data equal to the bench behavioural model of the engine.
REQ-047 Operands pushed with no command pending -> FIFO fills to 4 and opd_ready=0; the next push is blocked until LOAD pops.
REQ-048 cmd_op=11 -> err pulses once, cmd_ready stays 1 and no dm_* activity occurs.
REQ-049 rst_n low for one cycle during RUN, with res_ready held 0 -> FSM returns to IDLE, res_valid never asserts and the FIFO is empty.
